// File: rtl/dce_uart_rx_fifo.sv
// UART receiver for the DCE side: 2-flop input synchronizer, 8N1 frame FSM and a
// circular receive FIFO with RTS flow control, frame-error pulse and sticky overrun.
module dce_uart_rx_fifo #(
    parameter int DEPTH   = 8,
    parameter int MIN_DBR = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rxd,
    input  logic [15:0]            dbr,
    output logic                   rts,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    input  logic                   rd_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   MIN_DBR_W = 16'(MIN_DBR);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] RTS_CNT   = CW'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [1:0]    sync_reg;
    logic          rxs;
    state_t        state_reg;
    logic [15:0]   cnt_reg;
    logic [15:0]   eff_dbr_reg;
    logic [15:0]   eff_dbr_next;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          frame_err_reg;
    logic          overrun_reg;

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          rts_reg;
    logic [7:0]    mem [DEPTH];

    logic          half_hit;
    logic          bit_hit;
    logic          stop_hit;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    // Idle-high line: synchronizer resets to 1 so reset never looks like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rxd};
        end
    end

    assign rxs = sync_reg[1];

    always_comb begin
        eff_dbr_next = (dbr < MIN_DBR_W) ? MIN_DBR_W : dbr;
        half_hit     = (cnt_reg == ((eff_dbr_reg >> 1) - 16'd1));
        bit_hit      = (cnt_reg == (eff_dbr_reg - 16'd1));
        stop_hit     = (state_reg == STOP) && bit_hit;
        full         = (count_reg == FULL_CNT);
        pop          = (count_reg != '0) && rd_ready;
        push         = stop_hit && rxs && (!full || pop);
        drop         = stop_hit && rxs && full && !pop;
        count_next   = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Frame FSM: the divisor is captured at the start edge so later dbr changes
    // cannot disturb a frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_reg       <= '0;
            eff_dbr_reg   <= MIN_DBR_W;
            shift_reg     <= '0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            if (drop) begin
                overrun_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (!rxs) begin
                        eff_dbr_reg <= eff_dbr_next;
                        cnt_reg     <= '0;
                        bit_reg     <= '0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (half_hit) begin
                        cnt_reg   <= '0;
                        state_reg <= rxs ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_reg   <= bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_hit) begin
                        cnt_reg       <= '0;
                        frame_err_reg <= !rxs;
                        state_reg     <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // RTS looks at the post-update occupancy so it drops on the same edge the
    // count reaches the high-water mark.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rts_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            rts_reg   <= (count_next < RTS_CNT);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    assign rd_data    = mem[rd_ptr_reg];
    assign rd_valid   = (count_reg != '0);
    assign fifo_count = count_reg;
    assign rts        = rts_reg;
    assign frame_err  = frame_err_reg;
    assign overrun    = overrun_reg;

endmodule
